cvsd_frame_ctrl: RTL and testbench
==================================

// Module: cvsd_frame_ctrl
// PURPOSE
//  Sequencer for the CVSD encode path. Generates the sample strobe that advances the
//  sine source and CVSD encoder, and discards a warm-up run of encoder bits. Packs
//  the following bits MSB-first into FRAME_BITS-wide frames and hands them downstream
//  over a valid/ready interface. Sits between the 50 MHz CLOCK domain and the
//  frame sink; replaces free-running divided-clock operation with gated start/stop.
// PARAMETERS
//  DIV_N       5000  CLOCK cycles per sample strobe (50 MHz -> 10 kHz); >= 3
//  FRAME_BITS  8     encoder bits per output frame; >= 2
//  PRE_LEN     16    captured bits discarded after start (warm-up); >= 1
// PORTS
//  CLOCK        in   1           system clock, 50 MHz, all logic rising-edge
//  RESET        in   1           synchronous, active-high
//  start        in   1           1-cycle pulse; honoured only in IDLE
//  stop         in   1           1-cycle pulse; honoured in WARMUP/RUN
//  cvsd_bit     in   1           encoder output bit (V2), valid 1 cycle after sample_en
//  frame_ready  in   1           downstream accepts frame_data when high with frame_valid
//  sample_en    out  1           1-cycle strobe advancing sin source + encoder
//  frame_data   out  FRAME_BITS  packed frame, first-captured bit in MSB
//  frame_valid  out  1           frame_data holds an unaccepted frame
//  overrun      out  1           sticky: a completed frame was dropped
//  busy         out  1           state != IDLE
//  state        out  2           0 IDLE, 1 WARMUP, 2 RUN, 3 DRAIN
// BEHAVIOUR
//  Reset: every output 0, state IDLE, divider/bit counters/shift reg 0; RESET wins
//   over all other inputs, including mid-frame and with frame_valid high.
//  Divider: cnt held 0 in IDLE; cleared on IDLE->WARMUP; else counts 0..DIV_N-1, wraps.
//   sample_en=1 exactly in cycles where cnt==DIV_N-1 and state!=IDLE (period DIV_N).
//  Capture: cycle after a sample_en (cap=1), cvsd_bit is taken at that edge. A cap
//   pending when the FSM enters IDLE is discarded.
//  FSM:
//   IDLE  : start -> WARMUP; clears overrun and counters. stop ignored.
//   WARMUP: each cap increments pre_cnt, bit dropped; on PRE_LEN-th cap -> RUN.
//           stop -> IDLE next edge (stop beats a same-cycle final cap).
//   RUN   : each cap shifts bit in (sr <= {sr[FRAME_BITS-2:0],cvsd_bit}), bit_cnt++.
//           stop -> DRAIN if bit_cnt!=0 (or a same-cycle cap makes it !=0), else IDLE.
//   DRAIN : keep strobing/capturing until the current frame completes, then IDLE.
//  Frame completion: on the cap edge where bit_cnt reaches FRAME_BITS, bit_cnt<=0 and
//   frame is offered to the output register at that same edge (frame_valid visible
//   2 cycles after the final sample_en). Loaded if frame_valid==0 or
//   frame_ready==1 that cycle (same-cycle accept+reload allowed); else frame dropped,
//   overrun<=1, output register unchanged.
//  Handshake: transfer when frame_valid&&frame_ready; frame_valid falls next edge
//   unless reloaded. frame_data stable while frame_valid=1 and not transferred.
//   Pending frame survives transition to IDLE and is still drained by frame_ready.
//  Simultaneous start+stop in IDLE: start taken. start outside IDLE: ignored.
//  overrun cleared only by RESET or an accepted start.
// TESTING (bench uses DIV_N=4, FRAME_BITS=8, PRE_LEN=2)
//  1 RESET high 2 cycles with random inputs -> all outputs 0, state=0, no sample_en.
//  2 start, ready=1 -> sample_en every 4 cycles; 2 warm-up bits dropped; then bits
//    1,0,1,1,0,0,1,0 -> frame_data=8'hB2, frame_valid for 1 cycle, state=2.
//  3 ready=0 across 2 frames -> first frame held stable, second dropped, overrun=1;
//    ready=1 -> first frame transfers; new start clears overrun.
//  4 stop after 3 RUN bits -> state=3, 5 more strobes, frame emitted, state=0,
//    sample_en stays 0 afterwards.
//  5 stop during WARMUP -> state=0 next edge, no frame_valid ever.
//  6 RESET mid-RUN with frame_valid=1 and 5 bits buffered -> all cleared next edge;
//    following start produces a frame with no stale bits.

Source files
------------

// File: rtl/cvsd_frame_ctrl.sv
// CVSD encode-path sequencer: sample strobe, warm-up discard,
// MSB-first frame packing and valid/ready frame output.
module cvsd_frame_ctrl #(
   parameter int DIV_N      = 5000,
   parameter int FRAME_BITS = 8,
   parameter int PRE_LEN    = 16
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cvsd_bit,
   input  logic                  frame_ready,
   output logic                  sample_en,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic                  frame_valid,
   output logic                  overrun,
   output logic                  busy,
   output logic [1:0]            state
);

   localparam int CW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
   localparam int PW = $clog2(PRE_LEN + 1);
   localparam int BW = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [FRAME_BITS-1:0] fdata_q, fdata_d;
   logic                  fvalid_q, fvalid_d;
   logic                  ovr_q, ovr_d;
   logic                  cap_q, cap_d;
   logic                  strobe;
   logic                  done;
   logic [FRAME_BITS-1:0] word;

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      fdata_d   = fdata_q;
      fvalid_d  = fvalid_q;
      ovr_d     = ovr_q;
      cnt_d     = cnt_q;
      done      = 1'b0;
      word      = {sr_q[FRAME_BITS-2:0], cvsd_bit};
      strobe    = (state_q != S_IDLE) && (cnt_q == CW'(DIV_N - 1));

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_WARMUP;
               ovr_d     = 1'b0;
               pre_cnt_d = '0;
               bit_cnt_d = '0;
               sr_d      = '0;
            end
         end
         S_WARMUP: begin
            // stop wins over a final warm-up capture in the same cycle
            if (stop) begin
               state_d = S_IDLE;
            end else if (cap_q) begin
               if (pre_cnt_q == PW'(PRE_LEN - 1)) begin
                  state_d   = S_RUN;
                  pre_cnt_d = '0;
               end else begin
                  pre_cnt_d = pre_cnt_q + PW'(1);
               end
            end
         end
         S_RUN, S_DRAIN: begin
            if (cap_q) begin
               sr_d = word;
               if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                  bit_cnt_d = '0;
                  done      = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
            if (state_q == S_RUN && stop) begin
               state_d = (bit_cnt_d != '0) ? S_DRAIN : S_IDLE;
            end
            if (state_q == S_DRAIN && done) begin
               state_d = S_IDLE;
            end
         end
      endcase

      if (fvalid_q && frame_ready) begin
         fvalid_d = 1'b0;
      end
      // a finished frame is dropped only if the held one is not leaving
      if (done) begin
         if (!fvalid_q || frame_ready) begin
            fdata_d  = word;
            fvalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      if (state_q == S_IDLE || state_d == S_IDLE) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DIV_N - 1)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      cap_d = strobe && (state_d != S_IDLE);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pre_cnt_q <= '0;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         fdata_q   <= '0;
         fvalid_q  <= 1'b0;
         ovr_q     <= 1'b0;
         cap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pre_cnt_q <= pre_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         fdata_q   <= fdata_d;
         fvalid_q  <= fvalid_d;
         ovr_q     <= ovr_d;
         cap_q     <= cap_d;
      end
   end

   assign sample_en   = strobe;
   assign frame_data  = fdata_q;
   assign frame_valid = fvalid_q;
   assign overrun     = ovr_q;
   assign busy        = (state_q != S_IDLE);
   assign state       = state_q;

endmodule

// File: tb/tb_cvsd_frame_ctrl.sv
// Bench for cvsd_frame_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_cvsd_frame_ctrl;

   localparam int DIV = 4;
   localparam int FB  = 8;
   localparam int PRE = 2;

   logic          clk = 1'b0;
   logic          rst, start, stop, cvsd_bit, rdy;
   logic          sample_en, frame_valid, overrun, busy;
   logic [FB-1:0] frame_data;
   logic [1:0]    state;

   cvsd_frame_ctrl #(.DIV_N(DIV), .FRAME_BITS(FB), .PRE_LEN(PRE)) dut (
      .CLOCK(clk), .RESET(rst), .start(start), .stop(stop),
      .cvsd_bit(cvsd_bit), .frame_ready(rdy), .sample_en(sample_en),
      .frame_data(frame_data), .frame_valid(frame_valid),
      .overrun(overrun), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: 0 idle, 1 warm-up, 2 run, 3 drain
   int            m_mode, m_ticks, m_warm;
   bit            m_cap, m_fv, m_ovr;
   logic [FB-1:0] m_fd;
   bit            m_bits[$];
   bit            pat[$];

   int            n, cnt_se, seen;
   logic [FB-1:0] held;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic void m_clear();
      m_mode  = 0;
      m_ticks = 0;
      m_warm  = 0;
      m_cap   = 0;
      m_fv    = 0;
      m_ovr   = 0;
      m_fd    = '0;
      m_bits.delete();
   endfunction

   function automatic void m_step(bit se);
      int            nm;
      bit            offer;
      logic [FB-1:0] fr;
      if (rst) begin
         m_clear();
         return;
      end
      nm    = m_mode;
      offer = 0;
      fr    = '0;
      if (m_fv && rdy) m_fv = 0;
      case (m_mode)
         0: if (start) begin
            nm     = 1;
            m_warm = 0;
            m_ovr  = 0;
            m_bits.delete();
         end
         1: if (stop) nm = 0;
            else if (m_cap) begin
               m_warm++;
               if (m_warm == PRE) nm = 2;
            end
         default: begin
            if (m_cap) begin
               m_bits.push_back(cvsd_bit);
               if (m_bits.size() == FB) begin
                  foreach (m_bits[i]) fr = {fr[FB-2:0], m_bits[i]};
                  m_bits.delete();
                  offer = 1;
               end
            end
            if (m_mode == 2 && stop) nm = (m_bits.size() != 0) ? 3 : 0;
            if (m_mode == 3 && offer) nm = 0;
         end
      endcase
      if (offer) begin
         if (!m_fv) begin
            m_fd = fr;
            m_fv = 1;
         end else begin
            m_ovr = 1;
         end
      end
      m_ticks = (m_mode == 0 || nm == 0) ? 0 : m_ticks + 1;
      m_cap   = se && (nm != 0);
      m_mode  = nm;
   endfunction

   task automatic cycle();
      bit exp_se;
      if (m_cap && m_mode >= 2 && pat.size() > 0) cvsd_bit = pat.pop_front();
      else cvsd_bit = 1'($urandom_range(0, 1));
      exp_se = (m_mode != 0) && ((m_ticks % DIV) == DIV - 1);
      chk("sample_en", sample_en, exp_se);
      chk("state", state, m_mode);
      chk("busy", busy, m_mode != 0);
      chk("frame_valid", frame_valid, m_fv);
      chk("frame_data", frame_data, m_fd);
      chk("overrun", overrun, m_ovr);
      m_step(exp_se);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(int k);
      for (int i = 0; i < k; i++) cycle();
   endtask

   task automatic wait_fv(int budget);
      int k = 0;
      while (!m_fv && k < budget) begin
         cycle();
         k++;
      end
      chk("wait_fv_budget", k < budget, 1);
   endtask

   task automatic pulse_start();
      start = 1;
      cycle();
      start = 0;
   endtask

   task automatic load_pat();
      pat = '{1, 0, 1, 1, 0, 0, 1, 0};
   endtask

   initial begin
      rst = 1; start = 0; stop = 0; rdy = 0; cvsd_bit = 0;
      @(posedge clk);
      @(negedge clk);
      m_clear();

      // reset held with random inputs
      repeat (2) begin
         start = 1'($urandom_range(0, 1));
         stop  = 1'($urandom_range(0, 1));
         rdy   = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("rst_state", state, 0);
      chk("rst_se", sample_en, 0);
      rst = 0; start = 0; stop = 0;

      // first frame B2
      rdy = 1;
      load_pat();
      pulse_start();
      wait_fv(80);
      chk("t2_data", frame_data, 8'hB2);
      chk("t2_state", state, 2);
      cycle();
      chk("t2_valid_drop", frame_valid, 0);

      // back-pressure: hold, drop, overrun
      rdy = 0;
      wait_fv(80);
      held = m_fd;
      run(36);
      chk("t3_hold", frame_data, held);
      chk("t3_valid", frame_valid, 1);
      chk("t3_ovr", overrun, 1);
      rdy = 1;
      run(2);
      stop = 1;
      cycle();
      stop = 0;
      n = 0;
      while (state != 0 && n < 100) begin
         cycle();
         n++;
      end
      chk("t3_idle", state, 0);
      pulse_start();
      chk("t3_ovr_clr", overrun, 0);

      // stop after 3 run bits drains 5 more strobes
      n = 0;
      while (!(m_mode == 2 && m_bits.size() == 3) && n < 100) begin
         cycle();
         n++;
      end
      chk("t4_reach", n < 100, 1);
      stop = 1;
      cycle();
      stop = 0;
      chk("t4_drain", state, 3);
      cnt_se = 0;
      n = 0;
      while (state != 0 && n < 100) begin
         cnt_se += int'(sample_en);
         cycle();
         n++;
      end
      chk("t4_strobes", cnt_se, 5);
      chk("t4_fv", frame_valid, 1);
      seen = 0;
      repeat (20) begin
         seen |= int'(sample_en);
         cycle();
      end
      chk("t4_quiet", seen, 0);

      // stop during warm-up
      pulse_start();
      run(5);
      stop = 1;
      cycle();
      stop = 0;
      chk("t5_idle", state, 0);
      seen = 0;
      repeat (30) begin
         seen |= int'(frame_valid);
         cycle();
      end
      chk("t5_nofv", seen, 0);

      // reset mid-run with a pending frame and 5 bits buffered
      rdy = 0;
      pulse_start();
      wait_fv(80);
      n = 0;
      while (m_bits.size() != 5 && n < 100) begin
         cycle();
         n++;
      end
      chk("t6_pre_fv", frame_valid, 1);
      rst = 1;
      cycle();
      rst = 0;
      chk("t6_fv", frame_valid, 0);
      chk("t6_data", frame_data, 0);
      chk("t6_state", state, 0);
      rdy = 1;
      load_pat();
      pulse_start();
      wait_fv(80);
      chk("t6_fresh", frame_data, 8'hB2);

      // random traffic
      repeat (1500) begin
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 29) == 0);
         stop  = ($urandom_range(0, 59) == 0);
         rdy   = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rst = 0; start = 0; stop = 0;
      run(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
